drive_head_pos: RTL and testbench
=================================

# drive_head_pos

Parametrised floppy head positioner and track-dirty tracker for the Commodore drive cores (1541/1571 and later variants). It decodes the two-bit stepper phase from the drive logic into a clamped half-track position and tracks whether the current track buffer has been written. It issues save requests, with the captured pre-move position, to the SD track engine through a req/ack handshake. It also generates the write-protect sense toggle that tells DOS the disk has changed.

## Interface
Parameters:
- HT_W, 7: half-track counter width; track output is HT_W-1 bits.
- HT_MIN, 1: lowest reachable half-track.
- HT_MAX, 68: highest reachable half-track.
- HT_RESET, 36: half-track loaded on reset.
- CHG_W, 24: disk-change timer width.
- CHG_TIMEOUT, 15000000: clocks during which write-protect sense is inverted after a disk change.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  drive clock (32 MHz).
- reset  in  1  synchronous, active-high.
- stp  in  2  stepper phase from drive logic.
- mtr  in  1  spindle motor on.
- side  in  1  head select.
- buff_we  in  1  track buffer write strobe.
- disk_change  in  1  image change, level.
- disk_readonly  in  1  image read-only flag, sampled on the disk_change rising edge.
- save_ack  in  1  one-cycle ack from the track engine.
- half_track  out  HT_W  current head position.
- track  out  HT_W-1  half_track[HT_W-1:1], registered.
- save_req  out  1  level, held until save_ack.
- save_track  out  HT_W-1  track to write back, valid while save_req.
- save_side  out  1  side to write back, valid while save_req.
- save_ovf  out  1  sticky; a save was dropped.
- wps_n  out  1  write-protect sense, active low.
- tr00_sense_n  out  1  low when track == 0.
- bump  out  1  head-bump pulse (see Configuration).

## Operation
- stp_r <= stp every cycle, regardless of mtr.
- Step up: (stp_r,stp) = 0→1, 1→2, 2→3 or 3→0. Step down: 0→3, 3→2, 2→1 or 1→0. Diagonal transitions (stp_r^stp == 2) are ignored. Steps are acted on only when mtr=1.
- Step up increments half_track only if it is below HT_MAX. Step down decrements only if it is above HT_MIN.
- A valid step is a save trigger even when clamped. The other triggers are the mtr falling edge and any change of side (sampled side vs side_r).
- dirty is set by buff_we and cleared by reset or by a disk_change level.
- On a trigger with dirty=1 (including buff_we in the same cycle), capture {track, side_r}, which is the pre-move position, and clear dirty.
- Save FSM:
  - IDLE: on capture, go to PEND with save_req=1.
  - PEND: on save_ack, go to IDLE, or reload PEND from the queue if the queue is valid.
  - A capture while in PEND fills the one-deep queue. A capture while the queue is full is dropped and sets save_ovf.
- disk_change in the same cycle as a trigger means dirty is treated as 0 and no save occurs. An already pending or queued save is unaffected.
- Change timer:
  - A disk_change rising edge loads CHG_TIMEOUT and latches disk_readonly into readonly.
  - The timer decrements to 0; ch_state = (timer != 0), registered.
  - wps_n = ~readonly ^ ch_state.
- tr00_sense_n = |track.

## Timing
- A step is sampled at edge N, updates half_track at edge N+1, and updates track at N+2.
- Capture to save_req high: 1 cycle. save_ack to save_req low: 1 cycle. Queued save_req reasserts on the cycle after the ack, with no low gap.
- save_ack while in IDLE is ignored.
- Reset values:
  - half_track=HT_RESET, track=HT_RESET>>1.
  - save_req=0, queue empty, save_ovf=0, dirty=0.
  - timer=0, bump=0.
  - stp_r=stp, side_r=side.
  - readonly is not reset.
- Reset mid-PEND drops save_req in the same clock.

## Configuration
- DRIVE_HEAD_BUMP_EN defined: bump pulses for one cycle whenever a step-down is attempted at HT_MIN with mtr=1 (head banging against the stop). A step-up attempted at HT_MAX also pulses bump.
- DRIVE_HEAD_BUMP_EN undefined: bump is tied to 0 and no bump logic is generated.

## Test plan
- Reset, mtr=1, stp sequence 0,1,2,3,0 → half_track 36→40, track 20, no save_req (dirty=0).
- Pulse buff_we, then step 0→3 → save_req=1 one cycle after capture with save_track=18, save_side=0. Assert save_ack → save_req=0 on the next cycle.
- Dirty, step (save_req pending, no ack), write again, toggle side → queue filled. Ack → save_req stays high with the queued track/side. A third dirty trigger before that → save_ovf=1.
- Step down repeatedly from 36 → half_track stops at 1, tr00_sense_n=0. With DRIVE_HEAD_BUMP_EN, bump pulses on each further step; without it, bump stays 0.
- Stepping with mtr=0 → half_track unchanged. mtr 1→0 with dirty=1 → save_req.
- disk_change rise with disk_readonly=1, CHG_TIMEOUT=10 → wps_n=1 for 10 cycles, then 0. Dirty plus disk_change plus step in the same cycle → no save_req.

Source files
------------

// File: rtl/drive_head_pos.sv
// Floppy head positioner: stepper phase decode, clamped half-track position,
// dirty-track save requests and disk-change write-protect toggle. Optional head-bump pulse under DRIVE_HEAD_BUMP_EN.
module drive_head_pos #(
  parameter int HT_W        = 7,
  parameter int HT_MIN      = 1,
  parameter int HT_MAX      = 68,
  parameter int HT_RESET    = 36,
  parameter int CHG_W       = 24,
  parameter int CHG_TIMEOUT = 15000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      stp,
  input  logic            mtr,
  input  logic            side,
  input  logic            buff_we,
  input  logic            disk_change,
  input  logic            disk_readonly,
  input  logic            save_ack,
  output logic [HT_W-1:0] half_track,
  output logic [HT_W-2:0] track,
  output logic            save_req,
  output logic [HT_W-2:0] save_track,
  output logic            save_side,
  output logic            save_ovf,
  output logic            wps_n,
  output logic            tr00_sense_n,
  output logic            bump
);
  localparam logic [HT_W-1:0]  HT_MIN_V = HT_W'(HT_MIN);
  localparam logic [HT_W-1:0]  HT_MAX_V = HT_W'(HT_MAX);
  localparam logic [HT_W-1:0]  HT_RST_V = HT_W'(HT_RESET);
  localparam logic [CHG_W-1:0] CHG_V    = CHG_W'(CHG_TIMEOUT);

  typedef enum logic {IDLE, PEND} save_state_t;

  save_state_t state, state_n;
  logic [1:0]      stp_r;
  logic            side_r, mtr_r, dc_r, dirty;
  logic            up, dn, trigger, capture, dc_rise;
  logic            up_q, dn_q;
  logic            q_valid, q_side;
  logic [HT_W-2:0] q_track;
  logic            ld_cap, ld_q, q_fill, q_take, ovf_set;
  logic [CHG_W-1:0] timer;
  logic            ch_state, readonly;

  always_comb begin
    up      = mtr && (stp == stp_r + 2'd1);
    dn      = mtr && (stp == stp_r - 2'd1);
    trigger = up || dn || (mtr_r && !mtr) || (side != side_r);
    // a write landing in the trigger cycle still belongs to the old track
    capture = trigger && (dirty || buff_we) && !disk_change;
    dc_rise = disk_change && !dc_r;
  end

  // step decision is registered first, so the position moves one edge after sampling
  always_ff @(posedge clk) begin
    stp_r  <= stp;
    side_r <= side;
    mtr_r  <= mtr;
    if (reset) begin
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      half_track <= HT_RST_V;
      track      <= HT_RST_V[HT_W-1:1];
      dc_r       <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      up_q <= up;
      dn_q <= dn;
      if (up_q && half_track < HT_MAX_V)
        half_track <= half_track + HT_W'(1);
      else if (dn_q && half_track > HT_MIN_V)
        half_track <= half_track - HT_W'(1);
      track <= half_track[HT_W-1:1];
      dc_r  <= disk_change;
      if (disk_change || capture) dirty <= 1'b0;
      else if (buff_we)           dirty <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    ld_cap  = 1'b0;
    ld_q    = 1'b0;
    q_fill  = 1'b0;
    q_take  = 1'b0;
    ovf_set = 1'b0;
    case (state)
      IDLE: if (capture) begin
        state_n = PEND;
        ld_cap  = 1'b1;
      end
      PEND: begin
        if (save_ack) begin
          if (q_valid) begin
            ld_q   = 1'b1;
            q_take = 1'b1;
            q_fill = capture;
          end else if (capture) ld_cap = 1'b1;
          else state_n = IDLE;
        end else if (capture) begin
          if (!q_valid) q_fill  = 1'b1;
          else          ovf_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q_valid  <= 1'b0;
      save_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (q_fill)      q_valid <= 1'b1;
      else if (q_take) q_valid <= 1'b0;
      if (ovf_set) save_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_cap) begin
      save_track <= track;
      save_side  <= side_r;
    end else if (ld_q) begin
      save_track <= q_track;
      save_side  <= q_side;
    end
    if (q_fill) begin
      q_track <= track;
      q_side  <= side_r;
    end
  end

  assign save_req = (state == PEND) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer    <= '0;
      ch_state <= 1'b0;
    end else begin
      if (dc_rise)            timer <= CHG_V;
      else if (timer != '0)   timer <= timer - CHG_W'(1);
      ch_state <= (timer != '0);
    end
  end

  // readonly survives reset so the sense level stays tied to the mounted image
  always_ff @(posedge clk)
    if (dc_rise) readonly <= disk_readonly;

  assign wps_n        = ~readonly ^ ch_state;
  assign tr00_sense_n = |track;

`ifdef DRIVE_HEAD_BUMP_EN
  logic bump_r;
  always_ff @(posedge clk) begin
    if (reset) bump_r <= 1'b0;
    else       bump_r <= (dn_q && half_track == HT_MIN_V) || (up_q && half_track == HT_MAX_V);
  end
  assign bump = bump_r;
`else
  assign bump = 1'b0;
`endif
endmodule

// File: tb/tb_drive_head_pos.sv
// Directed bench for drive_head_pos: a cycle model (position, save queue, change window)
// is compared every cycle, plus hand-computed literal checks on key points.
module tb_drive_head_pos;
  localparam int CHG = 10;

  logic       clk = 1'b0, reset = 1'b1;
  logic [1:0] stp = 2'd0;
  logic       mtr = 1'b1, side = 1'b0, buff_we = 1'b0;
  logic       disk_change = 1'b0, disk_readonly = 1'b0, save_ack = 1'b0;
  logic [6:0] half_track;
  logic [5:0] track, save_track;
  logic       save_req, save_side, save_ovf, wps_n, tr00_sense_n, bump;

  drive_head_pos #(.HT_W(7), .HT_MIN(1), .HT_MAX(68), .HT_RESET(36),
                   .CHG_W(24), .CHG_TIMEOUT(CHG)) dut (
    .clk(clk), .reset(reset), .stp(stp), .mtr(mtr), .side(side), .buff_we(buff_we),
    .disk_change(disk_change), .disk_readonly(disk_readonly), .save_ack(save_ack),
    .half_track(half_track), .track(track), .save_req(save_req), .save_track(save_track),
    .save_side(save_side), .save_ovf(save_ovf), .wps_n(wps_n),
    .tr00_sense_n(tr00_sense_n), .bump(bump));

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: position with one-edge step latency, track one edge behind, save queue
  // of at most two entries (head is the one being requested)
  int m_ht, m_tr, m_pdir, m_prev, m_side_r, m_mtr_r, m_dirty, m_ovf, m_bump, m_dc_r, m_ro;
  int m_q[$];
  int cyc = 0, rise_cyc = -1000, d, nht, bmp;
  bit started = 0, m_ro_known = 0, trig, cap;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1;
      m_ht = 36; m_tr = 18; m_pdir = 0; m_dirty = 0; m_ovf = 0; m_bump = 0; m_dc_r = 0;
      rise_cyc = -1000;
      m_q.delete();
    end else begin
      d = 0;
      if (mtr) begin
        if (((int'(stp) - m_prev) & 3) == 1) d = 1;
        else if (((int'(stp) - m_prev) & 3) == 3) d = -1;
      end
      nht = m_ht; bmp = 0;
      if (m_pdir == 1) begin
        if (m_ht < 68) nht = m_ht + 1; else bmp = 1;
      end else if (m_pdir == -1) begin
        if (m_ht > 1) nht = m_ht - 1; else bmp = 1;
      end
      trig = (d != 0) || (m_mtr_r == 1 && !mtr) || (int'(side) != m_side_r);
      cap  = trig && (m_dirty == 1 || buff_we) && !disk_change;
      if (save_ack && m_q.size() > 0) void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() < 2) m_q.push_back(m_tr * 2 + m_side_r);
        else m_ovf = 1;
      end
      if (disk_change || cap) m_dirty = 0;
      else if (buff_we) m_dirty = 1;
      if (disk_change && m_dc_r == 0) begin
        rise_cyc = cyc; m_ro = int'(disk_readonly); m_ro_known = 1;
      end
      m_dc_r = int'(disk_change);
      m_tr = m_ht / 2;
      m_ht = nht;
      m_pdir = d;
`ifdef DRIVE_HEAD_BUMP_EN
      m_bump = bmp;
`else
      m_bump = 0;
`endif
    end
    m_prev = int'(stp); m_side_r = int'(side); m_mtr_r = int'(mtr);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("half_track", half_track, m_ht);
      chk("track", track, m_tr);
      chk("tr00_sense_n", tr00_sense_n, m_tr != 0);
      chk("save_req", save_req, m_q.size() > 0 && !reset);
      if (m_q.size() > 0 && !reset) begin
        chk("save_track", save_track, m_q[0] / 2);
        chk("save_side", save_side, m_q[0] % 2);
      end
      chk("save_ovf", save_ovf, m_ovf);
      chk("bump", bump, m_bump);
      if (m_ro_known)
        chk("wps_n", wps_n, (m_ro == 0) ^ ((cyc - rise_cyc) >= 1 && (cyc - rise_cyc) <= CHG));
    end
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("lit_rst_ht", half_track, 36);
    chk("lit_rst_track", track, 18);
    chk("lit_rst_req", save_req, 0);
    chk("lit_rst_ovf", save_ovf, 0);

    repeat (4) begin stp = stp + 2'd1; tick(); end
    tick(); tick();
    chk("lit_up_ht", half_track, 40);
    chk("lit_up_track", track, 20);
    chk("lit_up_req", save_req, 0);

    stp = stp + 2'd2; tick(); tick(); tick();
    chk("lit_diag_ht", half_track, 40);

    reset = 1'b1; tick(); reset = 1'b0;
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    stp = stp - 2'd1; tick();
    chk("lit_save_req", save_req, 1);
    chk("lit_save_track", save_track, 18);
    chk("lit_save_side", save_side, 0);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    chk("lit_ack_drop", save_req, 0);

    buff_we = 1'b1; tick(); buff_we = 1'b0;
    stp = stp - 2'd1; tick();
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    side = 1'b1; tick();
    chk("lit_q_ovf0", save_ovf, 0);
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    stp = stp - 2'd1; tick();
    chk("lit_ovf", save_ovf, 1);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    chk("lit_q_hold", save_req, 1);
    chk("lit_q_track", save_track, 17);
    chk("lit_q_side", save_side, 0);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    chk("lit_q_done", save_req, 0);

    buff_we = 1'b1; tick(); buff_we = 1'b0;
    side = 1'b0; tick();
    chk("lit_pend", save_req, 1);
    reset = 1'b1; #1;
    chk("lit_rst_mid", save_req, 0);
    tick(); reset = 1'b0;

    repeat (40) begin stp = stp - 2'd1; tick(); end
    tick(); tick();
    chk("lit_bottom_ht", half_track, 1);
    chk("lit_tr00", tr00_sense_n, 0);

    mtr = 1'b0;
    repeat (4) begin stp = stp + 2'd1; tick(); end
    tick(); tick();
    chk("lit_mtr_off_ht", half_track, 1);
    mtr = 1'b1; tick();
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    mtr = 1'b0; tick();
    chk("lit_mtr_fall_req", save_req, 1);
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    mtr = 1'b1; tick();

    repeat (72) begin stp = stp + 2'd1; tick(); end
    tick(); tick();
    chk("lit_top_ht", half_track, 68);

    save_ack = 1'b1; tick(); save_ack = 1'b0;
    chk("lit_idle_ack", save_req, 0);

    disk_readonly = 1'b1; disk_change = 1'b1; tick();
    disk_change = 1'b0; disk_readonly = 1'b0;
    repeat (4) tick();
    chk("lit_wps_chg", wps_n, 1);
    repeat (10) tick();
    chk("lit_wps_after", wps_n, 0);

    buff_we = 1'b1; tick(); buff_we = 1'b0;
    disk_change = 1'b1; stp = stp - 2'd1; tick();
    disk_change = 1'b0; tick();
    chk("lit_dc_nosave", save_req, 0);
    stp = stp - 2'd1; tick(); tick();
    chk("lit_dc_clean", save_req, 0);
    repeat (14) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
